// File: rtl/y86_pipe_pkg.sv
// Shared Y86 pipeline types: status/opcode codes, packed stage payload layout, bubble constants.
package y86_pipe_pkg;

    localparam int unsigned STAT_W  = 3;
    localparam int unsigned ICODE_W = 4;
    localparam int unsigned IFUN_W  = 4;
    localparam int unsigned VAL_W   = 64;
    localparam int unsigned REG_W   = 4;
    localparam int unsigned SPARE_W = 8;

    typedef enum logic [STAT_W-1:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4,
        STAT_BUB = 3'd5
    } stat_e;

    localparam logic [ICODE_W-1:0] ICODE_HALT = 4'h0;
    localparam logic [ICODE_W-1:0] ICODE_NOP  = 4'h1;
    localparam logic [REG_W-1:0]   RNONE      = 4'hF;

    // Spare byte pads the code/register nibble slots out to eight.
    typedef struct packed {
        logic [SPARE_W-1:0] spare;
        stat_e              stat;
        logic [ICODE_W-1:0] icode;
        logic [IFUN_W-1:0]  ifun;
        logic [VAL_W-1:0]   valc;
        logic [VAL_W-1:0]   vala;
        logic [VAL_W-1:0]   valb;
        logic [REG_W-1:0]   dste;
        logic [REG_W-1:0]   dstm;
        logic [REG_W-1:0]   srca;
        logic [REG_W-1:0]   srcb;
    } pipe_payload_t;

    localparam int unsigned PAYLOAD_W = $bits(pipe_payload_t);

    localparam int unsigned OFF_SRCB  = 0;
    localparam int unsigned OFF_SRCA  = OFF_SRCB  + REG_W;
    localparam int unsigned OFF_DSTM  = OFF_SRCA  + REG_W;
    localparam int unsigned OFF_DSTE  = OFF_DSTM  + REG_W;
    localparam int unsigned OFF_VALB  = OFF_DSTE  + REG_W;
    localparam int unsigned OFF_VALA  = OFF_VALB  + VAL_W;
    localparam int unsigned OFF_VALC  = OFF_VALA  + VAL_W;
    localparam int unsigned OFF_IFUN  = OFF_VALC  + VAL_W;
    localparam int unsigned OFF_ICODE = OFF_IFUN  + IFUN_W;
    localparam int unsigned OFF_STAT  = OFF_ICODE + ICODE_W;
    localparam int unsigned OFF_SPARE = OFF_STAT  + STAT_W;

    localparam pipe_payload_t E_BUBBLE = '{
        spare: '0,
        stat:  STAT_AOK,
        icode: ICODE_NOP,
        ifun:  '0,
        valc:  '0,
        vala:  '0,
        valb:  '0,
        dste:  RNONE,
        dstm:  RNONE,
        srca:  RNONE,
        srcb:  RNONE
    };

    localparam pipe_payload_t D_BUBBLE = E_BUBBLE;
    localparam pipe_payload_t M_BUBBLE = E_BUBBLE;
    localparam pipe_payload_t W_BUBBLE = E_BUBBLE;

    localparam logic [PAYLOAD_W-1:0] E_BUBBLE_VEC = E_BUBBLE;
    localparam logic [PAYLOAD_W-1:0] D_BUBBLE_VEC = D_BUBBLE;
    localparam logic [PAYLOAD_W-1:0] M_BUBBLE_VEC = M_BUBBLE;
    localparam logic [PAYLOAD_W-1:0] W_BUBBLE_VEC = W_BUBBLE;

    // True when a payload carries no architectural effect.
    function automatic logic payload_is_nop(input pipe_payload_t p);
        return (p.icode == ICODE_NOP) && (p.dste == RNONE) && (p.dstm == RNONE);
    endfunction

endpackage

// File: rtl/y86_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment); at_max flags count == MAX.
module y86_sat_counter
    import y86_pipe_pkg::*;
#(
    parameter int unsigned       WIDTH = 8,
    parameter logic [WIDTH-1:0]  MAX   = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             at_max
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next;

    always_comb begin
        w_next = r_count;
        if (clr) begin
            w_next = '0;
        end else if (inc && (r_count != MAX)) begin
            w_next = r_count + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    assign count  = r_count;
    assign at_max = (r_count == MAX);

endmodule

// File: rtl/y86_pipe_stage_reg.sv
// Generic Y86 pipeline stage register: stall/bubble control, valid tracking, stall watchdog.
// Optional perf counters (stall_cnt, bubble_cnt) enabled by defining PIPE_PERF_CNT_EN.
module y86_pipe_stage_reg
    import y86_pipe_pkg::*;
#(
    parameter int unsigned       W           = PAYLOAD_W,
    parameter logic [W-1:0]      BUBBLE_VAL  = '0,
    parameter int unsigned       STALL_LIMIT = 16,
    parameter int unsigned       CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             bubble,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    input  logic             timeout_clr,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic             ctrl_conflict,
    output logic             stall_timeout
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
`endif
);

    localparam int unsigned RUN_W = $clog2(STALL_LIMIT + 1);

    logic [W-1:0]     r_data;
    logic             r_valid;
    logic             r_conflict;
    logic             r_timeout;
    logic             w_run_inc;
    logic             w_run_clr;
    logic             w_run_hit;
    logic             w_run_at_max;
    logic [RUN_W-1:0] w_run_cnt;

    // Payload path: bubble > stall > load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= BUBBLE_VAL;
            r_valid <= 1'b0;
        end else if (bubble) begin
            r_data  <= BUBBLE_VAL;
            r_valid <= 1'b0;
        end else if (!stall) begin
            r_data  <= in_data;
            r_valid <= in_valid;
        end
    end

    // A stall-and-bubble cycle holds the run count: it neither extends nor breaks the run.
    assign w_run_inc = stall & ~bubble;
    assign w_run_clr = timeout_clr | ~stall;

    y86_sat_counter #(
        .WIDTH (RUN_W),
        .MAX   (RUN_W'(STALL_LIMIT))
    ) u_run_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (w_run_inc),
        .clr    (w_run_clr),
        .count  (w_run_cnt),
        .at_max (w_run_at_max)
    );

    assign w_run_hit = w_run_inc & ~timeout_clr &
                       (w_run_at_max | (w_run_cnt == RUN_W'(STALL_LIMIT - 1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_conflict <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_conflict <= stall & bubble;
            r_timeout  <= timeout_clr ? 1'b0 : (r_timeout | w_run_hit);
        end
    end

    assign out_data      = r_data;
    assign out_valid     = r_valid;
    assign ctrl_conflict = r_conflict;
    assign stall_timeout = r_timeout;

`ifdef PIPE_PERF_CNT_EN
    logic w_stall_max_unused;
    logic w_bubble_max_unused;

    // Lifetime totals; only reset clears them.
    y86_sat_counter #(
        .WIDTH (CNT_W),
        .MAX   ({CNT_W{1'b1}})
    ) u_stall_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (w_run_inc),
        .clr    (1'b0),
        .count  (stall_cnt),
        .at_max (w_stall_max_unused)
    );

    y86_sat_counter #(
        .WIDTH (CNT_W),
        .MAX   ({CNT_W{1'b1}})
    ) u_bubble_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (bubble),
        .clr    (1'b0),
        .count  (bubble_cnt),
        .at_max (w_bubble_max_unused)
    );
`else
    localparam int unsigned cnt_w_unused = CNT_W;
`endif

endmodule

// File: tb/tb_y86_pipe_stage_reg.sv
// Directed self-checking bench for y86_pipe_stage_reg (STALL_LIMIT=4; perf counters when PIPE_PERF_CNT_EN).
module tb_y86_pipe_stage_reg;
    import y86_pipe_pkg::*;

    localparam int unsigned W     = PAYLOAD_W;
    localparam int unsigned LIMIT = 4;
    localparam int unsigned CW    = 4;
    localparam logic [W-1:0] BUB  = E_BUBBLE_VEC;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         stall, bubble, in_valid, timeout_clr;
    logic [W-1:0] in_data;
    logic         out_valid, ctrl_conflict, stall_timeout;
    logic [W-1:0] out_data;
`ifdef PIPE_PERF_CNT_EN
    logic [CW-1:0] stall_cnt, bubble_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [W-1:0] pat_a5;

    y86_pipe_stage_reg #(
        .W           (W),
        .BUBBLE_VAL  (BUB),
        .STALL_LIMIT (LIMIT),
        .CNT_W       (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .bubble        (bubble),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .timeout_clr   (timeout_clr),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .ctrl_conflict (ctrl_conflict),
        .stall_timeout (stall_timeout)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt     (stall_cnt),
        .bubble_cnt    (bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then sample on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic s, input logic b, input logic v, input logic [W-1:0] d);
        stall    = s;
        bubble   = b;
        in_valid = v;
        in_data  = d;
    endtask

    initial begin
        pat_a5      = W'({29{8'hA5}});
        rst_n       = 1'b0;
        timeout_clr = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0);
        #12;
        check("rst_data", out_data, BUB);
        check("rst_valid", W'(out_valid), W'(1'b0));
        check("rst_conflict", W'(ctrl_conflict), W'(1'b0));
        check("rst_timeout", W'(stall_timeout), W'(1'b0));
        check("bubble_srcb_rnone", W'(out_data[3:0]), W'(4'hF));
        check("bubble_icode_nop", W'(out_data[OFF_ICODE +: 4]), W'(4'h1));
        @(negedge clk);
        rst_n = 1'b1;

        // Test 1: asynchronous reset between edges
        drive(1'b0, 1'b0, 1'b1, pat_a5);
        step();
        check("t1_loaded_data", out_data, pat_a5);
        check("t1_loaded_valid", W'(out_valid), W'(1'b1));
        #2 rst_n = 1'b0;
        #1;
        check("t1_async_data", out_data, BUB);
        check("t1_async_valid", W'(out_valid), W'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        check("t1_post_data", out_data, BUB);

        // Test 2: normal flow, valid follows in_valid
        drive(1'b0, 1'b0, 1'b1, W'(1));
        step();
        check("t2_d1", out_data, W'(1));
        check("t2_v1", W'(out_valid), W'(1'b1));
        drive(1'b0, 1'b0, 1'b0, W'(2));
        step();
        check("t2_d2", out_data, W'(2));
        check("t2_v2", W'(out_valid), W'(1'b0));
        drive(1'b0, 1'b0, 1'b1, W'(3));
        step();
        check("t2_d3", out_data, W'(3));
        check("t2_v3", W'(out_valid), W'(1'b1));

        // Test 3: stall holds contents
        drive(1'b0, 1'b0, 1'b1, W'(7));
        step();
        check("t3_load7", out_data, W'(7));
        drive(1'b1, 1'b0, 1'b0, W'(9));
        step();
        check("t3_hold1", out_data, W'(7));
        check("t3_hold1_valid", W'(out_valid), W'(1'b1));
        step();
        check("t3_hold2", out_data, W'(7));
        check("t3_no_timeout", W'(stall_timeout), W'(1'b0));
        drive(1'b0, 1'b0, 1'b1, W'(9));
        step();
        check("t3_release", out_data, W'(9));

        // Test 4: stall and bubble together
        drive(1'b1, 1'b1, 1'b1, W'(11));
        step();
        check("t4_data", out_data, BUB);
        check("t4_valid", W'(out_valid), W'(1'b0));
        check("t4_conflict", W'(ctrl_conflict), W'(1'b1));
        drive(1'b0, 1'b0, 1'b1, W'(5));
        step();
        check("t4_conflict_drop", W'(ctrl_conflict), W'(1'b0));
        check("t4_next_data", out_data, W'(5));

        // Test 5: watchdog, two short runs separated by a release
        for (int r = 0; r < 2; r++) begin
            drive(1'b1, 1'b0, 1'b1, W'(6));
            for (int i = 0; i < 3; i++) begin
                step();
                check("t5_short_run", W'(stall_timeout), W'(1'b0));
            end
            drive(1'b0, 1'b0, 1'b1, W'(6));
            step();
            check("t5_release", W'(stall_timeout), W'(1'b0));
        end
        drive(1'b1, 1'b0, 1'b0, W'(8));
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_run_pre", W'(stall_timeout), W'(1'b0));
        end
        step();
        check("t5_run_hit", W'(stall_timeout), W'(1'b1));
        step();
        check("t5_run_sat", W'(stall_timeout), W'(1'b1));
        check("t5_run_hold_data", out_data, W'(6));
        drive(1'b0, 1'b0, 1'b1, W'(12));
        step();
        check("t5_sticky", W'(stall_timeout), W'(1'b1));
        timeout_clr = 1'b1;
        drive(1'b0, 1'b0, 1'b1, W'(13));
        step();
        timeout_clr = 1'b0;
        check("t5_clr", W'(stall_timeout), W'(1'b0));
        check("t5_clr_payload", out_data, W'(13));
        // Clear during a stall restarts the run from zero
        drive(1'b1, 1'b0, 1'b1, W'(14));
        for (int i = 0; i < 2; i++) step();
        timeout_clr = 1'b1;
        step();
        timeout_clr = 1'b0;
        check("t5_clr_in_stall", W'(stall_timeout), W'(1'b0));
        for (int i = 0; i < 3; i++) step();
        check("t5_restart_pre", W'(stall_timeout), W'(1'b0));
        step();
        check("t5_restart_hit", W'(stall_timeout), W'(1'b1));
        drive(1'b0, 1'b0, 1'b1, W'(15));
        timeout_clr = 1'b1;
        step();
        timeout_clr = 1'b0;
        check("t5_final_clr", W'(stall_timeout), W'(1'b0));
        check("t5_final_data", out_data, W'(15));

`ifdef PIPE_PERF_CNT_EN
        // Test 6: perf counters saturate and only clear on reset
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t6_rst_stall_cnt", W'(stall_cnt), W'(0));
        check("t6_rst_bubble_cnt", W'(bubble_cnt), W'(0));
        drive(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 20; i++) step();
        drive(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 2; i++) step();
        drive(1'b0, 1'b0, 1'b0, '0);
        check("t6_stall_cnt", W'(stall_cnt), W'(15));
        check("t6_bubble_cnt", W'(bubble_cnt), W'(2));
        step();
        check("t6_stall_cnt_hold", W'(stall_cnt), W'(15));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
